// File: rtl/reset_conditioner_pkg.sv
// Shared reset-conditioner types: FSM state encodings, reset cause codes, sizing helper.
// Pure declarations; no latency or backpressure.
package reset_conditioner_pkg;

  typedef enum logic [1:0] {
    ASSERT   = 2'b00,
    HOLD     = 2'b01,
    RUN      = 2'b10,
    BTN_WAIT = 2'b11
  } rst_state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'b00,
    CAUSE_BTN = 2'b01,
    CAUSE_SW  = 2'b10
  } rst_cause_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: 2-flop sync, then the level flips after DEBOUNCE_CYCLES equal samples.
// Latency 2 + DEBOUNCE_CYCLES edges from a clean pin change; no backpressure.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic async_reset_n,
  input  logic btn_reset_n,
  output logic btn_pressed
);

  logic [1:0]       btn_sync;
  logic             level_q;
  logic [CNT_W-1:0] stable_cnt;

  // The count only runs while the sample differs from the accepted level, so
  // any sample matching the old level restarts the stability window.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      btn_sync   <= 2'b11;
      level_q    <= 1'b1;
      stable_cnt <= '0;
    end else begin
      btn_sync <= {btn_sync[0], btn_reset_n};
      if (btn_sync[1] == level_q) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q    <= btn_sync[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CNT_W'(1);
      end
    end
  end

  assign btn_pressed = ~level_q;

endmodule

// File: rtl/reset_conditioner.sv
// Conditioned system reset: immediate assert, synchronised + stretched release (SYNC_STAGES+1+HOLD_CYCLES edges).
// No backpressure; button/software causes are accepted only while running.
module reset_conditioner
  import reset_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 32
) (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       btn_reset_n,
  input  logic       sw_reset_req,
  output logic       async_reset,
  output logic       async_reset_out_n,
  output logic [1:0] reset_cause,
  output logic       ready
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, DEBOUNCE_CYCLES) + 1);

  logic [SYNC_STAGES-1:0] rel_sync;
  logic                   btn_pressed;
  rst_state_t             state_q, state_nxt;
  rst_cause_t             cause_q, cause_nxt;
  logic [CNT_W-1:0]       hold_cnt, hold_nxt;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debouncer (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .btn_reset_n   (btn_reset_n),
    .btn_pressed   (btn_pressed)
  );

  // Release synchroniser: a constant 1 ripples in once the board reset lifts.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      rel_sync <= '0;
    end else begin
      rel_sync <= {rel_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_comb begin
    state_nxt = state_q;
    cause_nxt = cause_q;
    hold_nxt  = hold_cnt;
    case (state_q)
      ASSERT: begin
        if (rel_sync[SYNC_STAGES-1]) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
          state_nxt = RUN;
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        // Button has priority over a coincident software request.
        if (btn_pressed) begin
          state_nxt = BTN_WAIT;
          cause_nxt = CAUSE_BTN;
        end else if (sw_reset_req) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
          cause_nxt = CAUSE_SW;
        end
      end
      BTN_WAIT: begin
        if (!btn_pressed) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = ASSERT;
      end
    endcase
  end

  // Outputs are registered from the next state so they flip on the same edge
  // as the state transition, with no combinational path to the reset net.
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q           <= ASSERT;
      cause_q           <= CAUSE_POR;
      hold_cnt          <= '0;
      async_reset       <= 1'b1;
      async_reset_out_n <= 1'b0;
      ready             <= 1'b0;
    end else begin
      state_q           <= state_nxt;
      cause_q           <= cause_nxt;
      hold_cnt          <= hold_nxt;
      async_reset       <= (state_nxt != RUN);
      async_reset_out_n <= (state_nxt == RUN);
      ready             <= (state_nxt == RUN);
    end
  end

  assign reset_cause = cause_q;

endmodule

// File: tb/tb_reset_conditioner.sv
// Self-checking bench for reset_conditioner: scoreboard of expected output snapshots keyed by clock edge.
module tb_reset_conditioner;

  localparam int S = 2;
  localparam int D = 16;
  localparam int H = 32;
  localparam logic [1:0] C_POR = 2'b00;
  localparam logic [1:0] C_BTN = 2'b01;
  localparam logic [1:0] C_SW  = 2'b10;

  logic       clk;
  logic       clk_en;
  logic       async_reset_n;
  logic       btn_reset_n;
  logic       sw_reset_req;
  logic       async_reset;
  logic       async_reset_out_n;
  logic [1:0] reset_cause;
  logic       ready;
  logic [4:0] obs;

  int tests_run;
  int tests_failed;
  int cyc;

  typedef struct {
    int         at;
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t sb[$];

  reset_conditioner #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .clk               (clk),
    .async_reset_n     (async_reset_n),
    .btn_reset_n       (btn_reset_n),
    .sw_reset_req      (sw_reset_req),
    .async_reset       (async_reset),
    .async_reset_out_n (async_reset_out_n),
    .reset_cause       (reset_cause),
    .ready             (ready)
  );

  assign obs = {async_reset, async_reset_out_n, ready, reset_cause};

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [4:0] in_rst(input logic [1:0] c);
    return {3'b100, c};
  endfunction

  function automatic logic [4:0] running(input logic [1:0] c);
    return {3'b011, c};
  endfunction

  // Keeps the scoreboard ordered by edge number.
  task automatic sb_push(input int at, input string tag, input logic [4:0] val);
    exp_t e;
    int   i;
    e.at  = at;
    e.tag = tag;
    e.val = val;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    check_eq("compl", {31'b0, async_reset_out_n}, {31'b0, ~async_reset});
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      if (e.at < cyc) check_eq({"late_", e.tag}, cyc, e.at);
      else            check_eq(e.tag, {27'b0, obs}, {27'b0, e.val});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (async_reset !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic sw_pulse();
    sw_reset_req = 1'b1;
    step(1);
    sw_reset_req = 1'b0;
  endtask

  initial begin
    int k;
    int m;
    int n;
    tests_run     = 0;
    tests_failed  = 0;
    clk_en        = 1'b0;
    async_reset_n = 1'b1;
    btn_reset_n   = 1'b1;
    sw_reset_req  = 1'b0;

    // POR with clock stopped: assertion must not need a clock.
    #2 async_reset_n = 1'b0;
    #1 check_eq("por_assert_noclk", {27'b0, obs}, {27'b0, in_rst(C_POR)});
    #40 check_eq("por_hold_noclk", {27'b0, obs}, {27'b0, in_rst(C_POR)});
    async_reset_n = 1'b1;
    sb_push(1, "por_e1", in_rst(C_POR));
    sb_push(S + H + 0, "por_e34", in_rst(C_POR));
    sb_push(S + H + 1, "por_e35", running(C_POR));
    #1 clk_en = 1'b1;
    step(S + H + 2);

    // Software reset: exactly H cycles asserted.
    k = cyc;
    sb_push(k + 1, "sw_asserted", in_rst(C_SW));
    sb_push(k + H, "sw_last_hold", in_rst(C_SW));
    sb_push(k + H + 1, "sw_released", running(C_SW));
    sw_pulse();
    step(H + 4);

    // Short button glitch is ignored; cause stays SW.
    k = cyc;
    for (int j = 1; j <= 6; j++) sb_push(k + 5 * j, "glitch_run", running(C_SW));
    btn_reset_n = 1'b0;
    step(10);
    btn_reset_n = 1'b1;
    step(25);

    // Bouncing button never stable for D samples.
    k = cyc;
    for (int j = 1; j <= 16; j++) sb_push(k + 5 * j, "bounce_run", running(C_SW));
    for (int i = 0; i < 20; i++) begin
      btn_reset_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    btn_reset_n = 1'b1;
    step(25);

    // Real press held well past the hold stretch: stays in reset until release.
    k = cyc;
    sb_push(k + 14, "btn_not_yet", running(C_SW));
    sb_push(k + 25, "btn_asserted", in_rst(C_BTN));
    sb_push(k + 59, "btn_wait_held", in_rst(C_BTN));
    btn_reset_n = 1'b0;
    step(60);
    btn_reset_n = 1'b1;
    wait_release(n);
    check_eq("btn_rel_latency", {31'b0, (n >= D + H && n <= D + H + 4)}, 32'd1);
    check_eq("btn_rel_cause", {27'b0, obs}, {27'b0, running(C_BTN)});
    step(5);

    // Software reset again so the collision has a distinct prior cause.
    k = cyc;
    sb_push(k + H + 1, "sw2_released", running(C_SW));
    sw_pulse();
    step(H + 4);

    // Debounced press recognised on the same edge as a software request.
    k = cyc;
    sb_push(k + 18, "coll_pre", running(C_SW));
    sb_push(k + 19, "coll_btn_wins", in_rst(C_BTN));
    sb_push(k + 55, "coll_btn_wait", in_rst(C_BTN));
    btn_reset_n = 1'b0;
    step(18);
    sw_pulse();
    step(42);
    btn_reset_n = 1'b1;
    wait_release(n);
    check_eq("coll_rel_latency", {31'b0, (n >= D + H && n <= D + H + 4)}, 32'd1);
    check_eq("coll_rel_cause", {27'b0, obs}, {27'b0, running(C_BTN)});
    step(5);

    // Board reset mid-HOLD (count 10): immediate, cause back to POR, full release again.
    k = cyc;
    sb_push(k + 1, "mid_sw_hold", in_rst(C_SW));
    sw_pulse();
    step(10);
    #2 async_reset_n = 1'b0;
    #1 check_eq("mid_async_assert", {27'b0, obs}, {27'b0, in_rst(C_POR)});
    step(3);
    m = cyc;
    sb_push(m + 1, "mid_e1", in_rst(C_POR));
    sb_push(m + S + H, "mid_e34", in_rst(C_POR));
    sb_push(m + S + H + 1, "mid_e35", running(C_POR));
    async_reset_n = 1'b1;
    step(S + H + 4);

    check_eq("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
